// File: rtl/key_loader_pkg.sv
// key_loader_pkg
// Shared definitions for the key-driven register-file loader:
//   - default parameter values (debounce length, address window)
//   - datapath widths
//   - FSM state encoding
//   - small helpers for pointer advance and operand extension
package key_loader_pkg;

    // 20 ms at 50 MHz.
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int unsigned ADDR_FIRST_DEF      = 1;
    localparam int unsigned ADDR_LAST_DEF       = 15;

    localparam int unsigned AddrW  = 4;
    localparam int unsigned DataW  = 16;
    localparam int unsigned SwW    = 10;
    localparam int unsigned CountW = 8;

    typedef logic [AddrW-1:0]  addr_t;
    typedef logic [DataW-1:0]  data_t;
    typedef logic [SwW-1:0]    sw_t;
    typedef logic [CountW-1:0] count_t;

    // FSM encoding kept as plain constants so older tools can read it.
    typedef logic [1:0] state_t;
    localparam state_t StIdle    = 2'd0;
    localparam state_t StReq     = 2'd1;
    localparam state_t StWrite   = 2'd2;
    localparam state_t StRelease = 2'd3;

    // Advance the write pointer, wrapping from last back to first.
    function automatic addr_t next_addr(input addr_t cur, input addr_t first, input addr_t last);
        return (cur == last) ? first : addr_t'(cur + addr_t'(1));
    endfunction

    // Zero-extend the switch operand to the register-file width.
    function automatic data_t sw_to_data(input sw_t sw);
        return {{(DataW - SwW){1'b0}}, sw};
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce
// Synchronises a raw active-low push-button and debounces it.
//
// Ports:
//   CLOCK_50   in   system clock, all state on rising edge
//   rst        in   asynchronous active-high reset
//   key_n_i    in   raw asynchronous active-low key
//   level_o    out  debounced key level (1 = released)
//   press_o    out  one-cycle pulse on a debounced 1->0 transition
//   release_o  out  one-cycle pulse on a debounced 0->1 transition
//
// The debounced level follows the synchronised level only after the two
// have differed for DEBOUNCE_CYCLES consecutive cycles; agreement at any
// point clears the count. The press/release pulses are registered so they
// line up with the first cycle of the new debounced level.
module key_debounce
    import key_loader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic CLOCK_50,
    input  logic rst,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            press_q, press_d;
    logic            release_q, release_d;

    // Two-flop synchroniser, reset to the released level.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        level_d   = level_q;
        cnt_d     = '0;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntLast) begin
                level_d   = sync2_q;
                press_d   = ~sync2_q;
                release_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            level_q   <= 1'b1;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/key_loader.sv
// key_loader
// Loads a switch operand into a register file on each debounced key press.
// A press latches the switches, requests the write port, writes one word
// at the current pointer once granted, then waits for the key release.
//
// Ports:
//   CLOCK_50  in   system clock, all state on rising edge
//   rst       in   asynchronous active-high reset
//   key_n     in   raw active-low load button
//   sw        in   10-bit operand, captured at the press
//   gnt       in   write-port grant, only looked at while requesting
//   req       out  write-port request, high throughout REQ
//   we        out  register-file write enable, one-cycle pulse
//   w_addr    out  register-file write address (held outside WRITE)
//   w_data    out  register-file write data (held outside WRITE)
//   busy      out  high whenever the FSM is not idle
//   wr_count  out  completed writes since reset, modulo 256
module key_loader
    import key_loader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned ADDR_FIRST      = ADDR_FIRST_DEF,
    parameter int unsigned ADDR_LAST       = ADDR_LAST_DEF
) (
    input  logic          CLOCK_50,
    input  logic          rst,
    input  logic          key_n,
    input  logic [9:0]    sw,
    input  logic          gnt,
    output logic          req,
    output logic          we,
    output logic [3:0]    w_addr,
    output logic [15:0]   w_data,
    output logic          busy,
    output logic [7:0]    wr_count
);

    localparam addr_t AddrFirst = addr_t'(ADDR_FIRST);
    localparam addr_t AddrLast  = addr_t'(ADDR_LAST);

    logic key_level;
    logic key_press;
    logic key_release;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .CLOCK_50  (CLOCK_50),
        .rst       (rst),
        .key_n_i   (key_n),
        .level_o   (key_level),
        .press_o   (key_press),
        .release_o (key_release)
    );

    state_t state_q,  state_d;
    data_t  data_q,   data_d;
    addr_t  ptr_q,    ptr_d;
    addr_t  w_addr_q, w_addr_d;
    data_t  w_data_q, w_data_d;
    count_t cnt_q,    cnt_d;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        ptr_d    = ptr_q;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                // Presses elsewhere are dropped, so a held key writes once.
                if (key_press) begin
                    data_d  = sw_to_data(sw);
                    state_d = StReq;
                end
            end
            StReq: begin
                // Load the write-port registers on the way into WRITE so they
                // are stable for the whole we pulse and hold afterwards.
                if (gnt) begin
                    w_addr_d = ptr_q;
                    w_data_d = data_q;
                    state_d  = StWrite;
                end
            end
            StWrite: begin
                ptr_d   = next_addr(ptr_q, AddrFirst, AddrLast);
                cnt_d   = cnt_q + count_t'(1);
                state_d = StRelease;
            end
            StRelease: begin
                // Level covers a release that happened before the grant.
                if (key_level || key_release) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            data_q   <= '0;
            ptr_q    <= AddrFirst;
            w_addr_q <= AddrFirst;
            w_data_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            ptr_q    <= ptr_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req      = (state_q == StReq);
    assign we       = (state_q == StWrite);
    assign busy     = (state_q != StIdle);
    assign w_addr   = w_addr_q;
    assign w_data   = w_data_q;
    assign wr_count = cnt_q;

endmodule

// File: doc/key_loader.md
KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive stable cycles needed to accept a key level (20 ms at 50 MHz).
REQ-002 Parameter ADDR_FIRST, default 1, is the first register-file address written after reset.
REQ-003 Parameter ADDR_LAST, default 15, is the last address written before the pointer wraps.
REQ-004 CLOCK_50  input  1  system clock, 50 MHz; all state SHALL be updated on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 key_n  input  1  raw, asynchronous, active-low load push-button.
REQ-007 sw  input  10  operand switches, sampled on an accepted press.
REQ-008 gnt  input  1  write-port grant from the datapath owner; sampled only in state REQ.
REQ-009 req  output  1  write-port request; high for the whole REQ state.
REQ-010 we  output  1  register-file write enable; one-cycle pulse.
REQ-011 w_addr  output  4  register-file write address.
REQ-012 w_data  output  16  register-file write data.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 wr_count  output  8  number of completed writes since reset, modulo 256.

Function
REQ-015 key_n SHALL pass through a two-flop synchroniser before any other use.
REQ-016 Debounce: the debounced level SHALL change only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-017 A press event SHALL be a single-cycle pulse on a debounced 1->0 transition of key_n; a release is a debounced 0->1 transition.
REQ-018 FSM states SHALL be IDLE, REQ, WRITE and RELEASE.
REQ-019 IDLE: on a press event, latch {6'b0, sw} into the data register and enter REQ on the next cycle.
REQ-020 REQ: hold req=1 and wait indefinitely; gnt=1 sampled in REQ enters WRITE on the next cycle.
REQ-021 WRITE: assert we=1 for exactly one cycle with w_addr equal to the pointer and w_data equal to the latched data; req=0; then enter RELEASE.
REQ-022 Each write SHALL advance the pointer by 1, wrapping from ADDR_LAST to ADDR_FIRST, and increment wr_count, wrapping 255->0.
REQ-023 RELEASE: wait for the debounced key level to be released, then return to IDLE.
REQ-024 Press events outside IDLE SHALL be ignored; a key held down produces exactly one write.
REQ-025 The sw value SHALL be captured only at the press event; later sw changes SHALL NOT affect w_data.
REQ-026 Latency: a press event to req=1 is 1 cycle; gnt sampled high to we=1 is 1 cycle.
REQ-027 If the key is released before gnt arrives, the write SHALL still complete; RELEASE then exits on the next cycle.
REQ-028 w_addr and w_data SHALL hold their values outside WRITE; we SHALL be 0 outside WRITE.

Reset
REQ-029 rst SHALL force state=IDLE, req=0, we=0, busy=0, w_data=0, wr_count=0, pointer=ADDR_FIRST, w_addr=ADDR_FIRST, synchroniser and debounced level=1 (released), and debounce counter=0.
REQ-030 rst asserted mid-operation (REQ or WRITE) SHALL abort with no write; the first press after rst deasserts writes ADDR_FIRST.

Structure
REQ-031 The state encoding and the DEBOUNCE_CYCLES, ADDR_FIRST and ADDR_LAST defaults SHALL live in the shared package.
REQ-032 The synchroniser and debounce logic SHALL be one sub-module, key_debounce, outputting the debounced level and the press/release pulses; key_loader instantiates it.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 Clean press with sw=10'h2A5 and gnt tied high -> exactly one we pulse, w_addr=1, w_data=16'h02A5, wr_count=1.
REQ-034 Bounce on key_n of 0/1/0 with each level held 2 cycles, then low for 10 cycles -> exactly one write; bounce shorter than 4 cycles alone -> no write.
REQ-035 gnt held low for 20 cycles after a press -> req=1 for all 20 cycles, we=0; gnt high -> we pulse exactly 1 cycle later; sw changed meanwhile -> w_data keeps the captured value.
REQ-036 16 press/release cycles -> addresses 1..15, then 1 again (wrap); wr_count=16.
REQ-037 rst pulsed while in REQ -> no we pulse, outputs at reset values; the next press writes address 1.
REQ-038 Key held low for 100 cycles with gnt high -> a single write, busy high until the debounced release.
